// File: rtl/sdram_pixel_unpacker.sv
`timescale 1ns/1ps
// Raster timing, SDRAM read-FIFO strobes and 16b word pair -> 10b RGB unpack; SDRAM_PIXEL_UNPACKER_TEST_PATTERN_EN adds iPattern colour bars.
// Latency: RD_LAT clocks read-to-data, then 1 registered clock counter-to-pins (syncs/DE/colour aligned).
// No backpressure: reads issue even when a FIFO is empty; that pixel is zeroed and oUnderflow set.
module sdram_pixel_unpacker #(
  parameter int H_ACTIVE = 800,
  parameter int H_SYNC_W = 1,
  parameter int H_BACK   = 215,
  parameter int H_TOTAL  = 1056,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC_W = 1,
  parameter int V_BACK   = 34,
  parameter int V_TOTAL  = 525,
  parameter int RD_LAT   = 1
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iEnable,
`ifdef SDRAM_PIXEL_UNPACKER_TEST_PATTERN_EN
  input  logic        iPattern,
`endif
  input  logic [15:0] iRd1_data,
  input  logic [15:0] iRd2_data,
  input  logic        iRdEmpty,
  output logic        oRead,
  output logic        oFrameStart,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oDE,
  output logic        oHS,
  output logic        oVS,
  output logic        oUnderflow
);

  localparam int H_START = H_SYNC_W + H_BACK;
  localparam int V_START = V_SYNC_W + V_BACK;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int HW1 = HW + 1;
  localparam int VW1 = VW + 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]  H_SYNC_C = HW'(H_SYNC_W);
  localparam logic [VW-1:0]  V_SYNC_C = VW'(V_SYNC_W);
  localparam logic [HW1-1:0] H_WIN_LO = HW1'(H_START);
  localparam logic [HW1-1:0] H_WIN_HI = HW1'(H_START + H_ACTIVE);
  localparam logic [VW1-1:0] V_WIN_LO = VW1'(V_START);
  localparam logic [VW1-1:0] V_WIN_HI = VW1'(V_START + V_ACTIVE);
  localparam logic [HW1-1:0] H_TOT_W  = HW1'(H_TOTAL);
  localparam logic [HW1-1:0] RD_LAT_W = HW1'(RD_LAT);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [HW1-1:0]    h_ahead;
  logic [VW1-1:0]    v_ahead;
  logic [RD_LAT-1:0] emp_pipe;
  logic              run, h_wrap, frame_end, sample, rd_empty_dly, uf_set;
  logic              pat_frame;
  logic [2:0]        pat_rgb;
  logic [9:0]        pix_r, pix_g, pix_b;
  logic              unused_flags;

  function automatic logic in_win(input logic [HW1-1:0] h, input logic [VW1-1:0] v);
    return (h >= H_WIN_LO) && (h < H_WIN_HI) && (v >= V_WIN_LO) && (v < V_WIN_HI);
  endfunction

  assign run          = (state_q == RUN);
  assign h_wrap       = (h_cnt == H_LAST);
  assign frame_end    = run && h_wrap && (v_cnt == V_LAST);
  assign sample       = run && in_win({1'b0, h_cnt}, {1'b0, v_cnt});
  assign oFrameStart  = run && (h_cnt == '0) && (v_cnt == '0);
  assign rd_empty_dly = emp_pipe[RD_LAT-1];
  assign uf_set       = sample && rd_empty_dly && !pat_frame;
  assign unused_flags = iRd1_data[15] ^ iRd2_data[15];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iEnable) state_d = RUN;
      RUN:     if (frame_end && !iEnable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Raster position RD_LAT clocks ahead, carrying into the next line on wrap.
  always_comb begin
    h_ahead = {1'b0, h_cnt} + RD_LAT_W;
    v_ahead = {1'b0, v_cnt};
    if (h_ahead >= H_TOT_W) begin
      h_ahead = h_ahead - H_TOT_W;
      v_ahead = (v_cnt == V_LAST) ? '0 : v_ahead + 1'b1;
    end
  end

  assign oRead = run && !pat_frame && in_win(h_ahead, v_ahead);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      emp_pipe <= '0;
    end else begin
      emp_pipe[0] <= oRead & iRdEmpty;
      for (int i = 1; i < RD_LAT; i++) emp_pipe[i] <= emp_pipe[i-1];
    end
  end

`ifdef SDRAM_PIXEL_UNPACKER_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;
  logic          pat_q;
  logic [HW-1:0] h_off, bar_idx;
  logic          unused_bar;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                          pat_q <= 1'b0;
    else if ((!run || frame_end) && iEnable) pat_q <= iPattern;
  end

  assign h_off      = h_cnt - HW'(H_START);
  assign bar_idx    = h_off / HW'(BAR_W);
  assign unused_bar = |bar_idx;
  assign pat_frame  = run && pat_q;
  // Bar order white,yellow,cyan,green,magenta,red,blue,black falls out of the index bits.
  assign pat_rgb    = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};
`else
  assign pat_frame = 1'b0;
  assign pat_rgb   = 3'b000;
`endif

  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (sample) begin
      if (pat_frame) begin
        pix_r = {10{pat_rgb[2]}};
        pix_g = {10{pat_rgb[1]}};
        pix_b = {10{pat_rgb[0]}};
      end else if (!rd_empty_dly) begin
        pix_r = iRd2_data[9:0];
        pix_g = {iRd1_data[14:10], iRd2_data[14:10]};
        pix_b = iRd1_data[9:0];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oHS        <= 1'b1;
      oVS        <= 1'b1;
      oDE        <= 1'b0;
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
      oUnderflow <= 1'b0;
    end else begin
      oHS    <= !(run && (h_cnt < H_SYNC_C));
      oVS    <= !(run && (v_cnt < V_SYNC_C));
      oDE    <= sample;
      oRed   <= pix_r;
      oGreen <= pix_g;
      oBlue  <= pix_b;
      if (uf_set)           oUnderflow <= 1'b1;
      else if (oFrameStart) oUnderflow <= 1'b0;
    end
  end

endmodule
